wb_stage_pipe: RTL and testbench

Registered, parametrised writeback stage of the lapido core pipeline. Sits between the MEM stage and the register file / fetch redirect logic. Captures MEM-stage results into a pipeline register with stall and flush control, and selects the writeback value from four sources. Emits a single-shot control-transfer redirect and counts retired instructions.

---
 rtl/wb_stage_pipe_if.sv | 52 +++++
 rtl/wb_stage_pipe.sv | 161 ++++++++++++++++
 tb/tb_wb_stage_pipe.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_pipe_if.sv
// wb_stage_pipe_if: bundle between the MEM stage (master) and the writeback
// stage (slave). Carries pipeline control, the MEM-stage result fields and the
// registered writeback / redirect / retire outputs.
interface wb_stage_pipe_if #(
   parameter int DATA_WIDTH     = 32,
   parameter int PC_WIDTH       = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int CNT_WIDTH      = 32
);
   logic                      stall;
   logic                      flush;
   logic                      in_valid;
   logic                      in_is_jump;
   logic                      in_branch_taken;
   logic [PC_WIDTH-1:0]       in_branch_addr;
   logic [PC_WIDTH-1:0]       in_jump_addr;
   logic                      in_reg_write_enable;
   logic [1:0]                in_wb_res_mux;
   logic [DATA_WIDTH-1:0]     in_alu_res;
   logic [DATA_WIDTH-1:0]     in_mem_data;
   logic [PC_WIDTH-1:0]       in_next_pc;
   logic [DATA_WIDTH-1:0]     in_imm;
   logic [REG_ADDR_WIDTH-1:0] in_reg_dst;
   logic [1:0]                in_mem_size;
   logic                      in_mem_signed;
   logic [1:0]                in_mem_byte_off;
   logic                      out_valid;
   logic                      out_reg_write_enable;
   logic [REG_ADDR_WIDTH-1:0] out_reg_dst;
   logic [DATA_WIDTH-1:0]     wb_res;
   logic                      out_redirect;
   logic [PC_WIDTH-1:0]       out_redirect_addr;
   logic [CNT_WIDTH-1:0]      retired_count;

   modport master (
      output stall, flush, in_valid, in_is_jump, in_branch_taken,
             in_branch_addr, in_jump_addr, in_reg_write_enable,
             in_wb_res_mux, in_alu_res, in_mem_data, in_next_pc, in_imm,
             in_reg_dst, in_mem_size, in_mem_signed, in_mem_byte_off,
      input  out_valid, out_reg_write_enable, out_reg_dst, wb_res,
             out_redirect, out_redirect_addr, retired_count
   );

   modport slave (
      input  stall, flush, in_valid, in_is_jump, in_branch_taken,
             in_branch_addr, in_jump_addr, in_reg_write_enable,
             in_wb_res_mux, in_alu_res, in_mem_data, in_next_pc, in_imm,
             in_reg_dst, in_mem_size, in_mem_signed, in_mem_byte_off,
      output out_valid, out_reg_write_enable, out_reg_dst, wb_res,
             out_redirect, out_redirect_addr, retired_count
   );
endinterface

// File: rtl/wb_stage_pipe.sv
// wb_stage_pipe: registered writeback stage of the lapido core.
// Captures MEM-stage results under stall/flush control, selects the
// writeback value from ALU / memory / link PC / immediate, emits a one-shot
// fetch redirect per control-transfer instruction and counts retirements.
// Optional feature macro: WB_LOAD_EXT_EN -- when defined, the memory source
// is byte/half/word extracted and sign- or zero-extended; otherwise the raw
// load word is written back unchanged.
module wb_stage_pipe #(
   parameter int DATA_WIDTH     = 32,
   parameter int PC_WIDTH       = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int CNT_WIDTH      = 32
) (
   input  logic          clk,
   input  logic          rst,
   wb_stage_pipe_if.slave bus
);

   // Capture happens when not stalled; a flush forces a capture so the
   // killed instruction is replaced by a bubble even while stalled.
   logic                      w_cap;
   logic [DATA_WIDTH-1:0]     w_mem_sel;
   logic [DATA_WIDTH-1:0]     w_next_pc_ext;
   logic [DATA_WIDTH-1:0]     w_wb_sel;
   logic [PC_WIDTH-1:0]       w_redirect_tgt;
   logic                      w_redirect;

   logic                      r_valid;
   logic                      r_we;
   logic [REG_ADDR_WIDTH-1:0] r_dst;
   logic [DATA_WIDTH-1:0]     r_wb_res;
   logic                      r_taken;
   logic                      r_jump;
   logic [PC_WIDTH-1:0]       r_redirect_addr;
   logic                      r_fired;
   logic [CNT_WIDTH-1:0]      r_retired;

   assign w_cap = !bus.stall || bus.flush;

`ifdef WB_LOAD_EXT_EN
   // Pick the addressed byte/half lane and extend it to the data width.
   // Size 2'b11 is treated as a full word.
   function automatic logic [DATA_WIDTH-1:0] load_extract(
      input logic [DATA_WIDTH-1:0] data,
      input logic [1:0]            size,
      input logic                  sgn,
      input logic [1:0]            off
   );
      logic [7:0]            lane_b;
      logic [15:0]           lane_h;
      logic [DATA_WIDTH-1:0] res;
      lane_b = data[{off, 3'b000} +: 8];
      lane_h = data[{off[1], 4'b0000} +: 16];
      case (size)
         2'b00:   res = {{(DATA_WIDTH-8){sgn & lane_b[7]}}, lane_b};
         2'b01:   res = {{(DATA_WIDTH-16){sgn & lane_h[15]}}, lane_h};
         default: res = data;
      endcase
      return res;
   endfunction

   assign w_mem_sel = load_extract(bus.in_mem_data, bus.in_mem_size,
                                   bus.in_mem_signed, bus.in_mem_byte_off);
`else
   // Load shaping controls have no effect when extraction is compiled out.
   logic w_unused_load_ctrl;
   assign w_unused_load_ctrl = ^{bus.in_mem_size, bus.in_mem_signed, bus.in_mem_byte_off};
   assign w_mem_sel          = bus.in_mem_data;
`endif

   // Writeback source select, evaluated on the pre-register inputs.
   always_comb begin
      w_next_pc_ext                 = '0;
      w_next_pc_ext[PC_WIDTH-1:0]   = bus.in_next_pc;
      w_wb_sel                      = bus.in_alu_res;
      case (bus.in_wb_res_mux)
         2'd0:    w_wb_sel = bus.in_alu_res;
         2'd1:    w_wb_sel = w_mem_sel;
         2'd2:    w_wb_sel = w_next_pc_ext;
         2'd3:    w_wb_sel = bus.in_imm;
         default: w_wb_sel = bus.in_alu_res;
      endcase
   end

   // Redirect target: a taken branch wins over a jump; neither gives zero.
   always_comb begin
      w_redirect_tgt = '0;
      if (bus.in_branch_taken) begin
         w_redirect_tgt = bus.in_branch_addr;
      end else if (bus.in_is_jump) begin
         w_redirect_tgt = bus.in_jump_addr;
      end else begin
         w_redirect_tgt = '0;
      end
   end

   // Pipeline register: load on capture, hold while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid         <= 1'b0;
         r_we            <= 1'b0;
         r_dst           <= '0;
         r_wb_res        <= '0;
         r_taken         <= 1'b0;
         r_jump          <= 1'b0;
         r_redirect_addr <= '0;
      end else if (w_cap) begin
         r_valid         <= bus.in_valid && !bus.flush;
         r_we            <= bus.in_reg_write_enable;
         r_dst           <= bus.in_reg_dst;
         r_wb_res        <= w_wb_sel;
         r_taken         <= bus.in_branch_taken;
         r_jump          <= bus.in_is_jump;
         r_redirect_addr <= w_redirect_tgt;
      end else begin
         r_valid         <= r_valid;
         r_we            <= r_we;
         r_dst           <= r_dst;
         r_wb_res        <= r_wb_res;
         r_taken         <= r_taken;
         r_jump          <= r_jump;
         r_redirect_addr <= r_redirect_addr;
      end
   end

   // Remember that the held instruction already redirected fetch, so a
   // multi-cycle stall yields a single pulse; a new capture re-arms it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fired <= 1'b0;
      end else if (w_cap) begin
         r_fired <= 1'b0;
      end else if (w_redirect) begin
         r_fired <= 1'b1;
      end else begin
         r_fired <= r_fired;
      end
   end

   // Retired-instruction counter, wraps naturally at its width.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_retired <= '0;
      end else if (w_cap && bus.in_valid && !bus.flush) begin
         r_retired <= r_retired + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         r_retired <= r_retired;
      end
   end

   // Strobes are pure ANDs of register outputs; r0 writes are suppressed.
   assign w_redirect               = r_valid && (r_taken || r_jump) && !r_fired;
   assign bus.out_valid            = r_valid;
   assign bus.out_reg_write_enable = r_valid && r_we && (r_dst != '0);
   assign bus.out_reg_dst          = r_dst;
   assign bus.wb_res               = r_wb_res;
   assign bus.out_redirect         = w_redirect;
   assign bus.out_redirect_addr    = r_redirect_addr;
   assign bus.retired_count        = r_retired;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// tb_wb_stage_pipe: scoreboard bench for wb_stage_pipe. The stimulus process
// drives one input vector per cycle and pushes the expected post-edge outputs
// from an instruction-level reference model; a monitor pops and compares.
module tb_wb_stage_pipe;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wb_stage_pipe_if bus ();

   wb_stage_pipe dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic        rst, stall, flush, valid, jump, taken, we, sgn;
      logic [31:0] baddr, jaddr, alu, mem, npc, imm;
      logic [1:0]  sel, size, off;
      logic [4:0]  dst;
   } stim_t;

   typedef struct packed {
      logic        valid, we, redir;
      logic [4:0]  dst;
      logic [31:0] wb, raddr, cnt;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   redir_seen = 0;
   int   we_seen = 0;
   bit   win_en = 1'b0;

   // Reference model: the instruction currently sitting in writeback.
   bit          m_valid, m_we, m_cti, m_done;
   logic [4:0]  m_dst;
   logic [31:0] m_wb, m_raddr, m_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [1:0] size,
                                            input logic sgn, input logic [1:0] off);
      logic [31:0] v;
`ifdef WB_LOAD_EXT_EN
      if (size == 2'b00) begin
         v = (d >> (8 * off)) & 32'h0000_00FF;
         if (sgn && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end else if (size == 2'b01) begin
         v = (d >> (16 * (off / 2))) & 32'h0000_FFFF;
         if (sgn && v >= 32'd32768) v = v + 32'hFFFF_0000;
      end else begin
         v = d;
      end
`else
      v = d;
`endif
      return v;
   endfunction

   function automatic logic [31:0] ref_wb(input stim_t s);
      case (s.sel)
         2'd0:    return s.alu;
         2'd1:    return ref_load(s.mem, s.size, s.sgn, s.off);
         2'd2:    return s.npc;
         default: return s.imm;
      endcase
   endfunction

   function automatic stim_t blank();
      stim_t s;
      s = '0;
      return s;
   endfunction

   // Drive one vector, advance the model across the coming edge, push expectations.
   task automatic step(input stim_t s);
      exp_t e;
      bit   shown;
      @(negedge clk);
      rst                     = s.rst;
      bus.stall               = s.stall;
      bus.flush               = s.flush;
      bus.in_valid            = s.valid;
      bus.in_is_jump          = s.jump;
      bus.in_branch_taken     = s.taken;
      bus.in_branch_addr      = s.baddr;
      bus.in_jump_addr        = s.jaddr;
      bus.in_reg_write_enable = s.we;
      bus.in_wb_res_mux       = s.sel;
      bus.in_alu_res          = s.alu;
      bus.in_mem_data         = s.mem;
      bus.in_next_pc          = s.npc;
      bus.in_imm              = s.imm;
      bus.in_reg_dst          = s.dst;
      bus.in_mem_size         = s.size;
      bus.in_mem_signed       = s.sgn;
      bus.in_mem_byte_off     = s.off;
      shown = m_valid && m_cti && !m_done;
      if (s.rst) begin
         m_valid = 0; m_we = 0; m_cti = 0; m_done = 0;
         m_dst = '0; m_wb = '0; m_raddr = '0; m_cnt = '0;
      end else if (!s.stall || s.flush) begin
         m_valid = s.valid && !s.flush;
         m_we    = s.we;
         m_dst   = s.dst;
         m_wb    = ref_wb(s);
         m_cti   = s.taken || s.jump;
         m_raddr = s.taken ? s.baddr : (s.jump ? s.jaddr : 32'h0);
         m_done  = 0;
         if (m_valid) m_cnt = m_cnt + 32'd1;
      end else if (shown) begin
         m_done = 1;
      end
      e.valid = m_valid;
      e.we    = m_valid && m_we && (m_dst != 5'd0);
      e.redir = m_valid && m_cti && !m_done;
      e.dst   = m_dst;
      e.wb    = m_wb;
      e.raddr = m_raddr;
      e.cnt   = m_cnt;
      exp_q.push_back(e);
   endtask

   // Monitor: after each edge, compare the DUT against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (win_en) begin
            if (bus.out_redirect) redir_seen++;
            if (bus.out_reg_write_enable) we_seen++;
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out_valid", {31'd0, bus.out_valid}, {31'd0, e.valid});
            chk("out_reg_write_enable", {31'd0, bus.out_reg_write_enable}, {31'd0, e.we});
            chk("out_redirect", {31'd0, bus.out_redirect}, {31'd0, e.redir});
            chk("retired_count", bus.retired_count, e.cnt);
            chk("out_redirect_addr", bus.out_redirect_addr, e.raddr);
            chk("wb_res", bus.wb_res, e.wb);
            chk("out_reg_dst", {27'd0, bus.out_reg_dst}, {27'd0, e.dst});
         end
      end
   end

   // Hard time limit so the run always ends.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Stimulus: directed scenarios first, then randomized traffic.
   initial begin
      stim_t s;
      s = blank();
      rst = 1'b1;
      bus.stall = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_is_jump = 1'b0;
      bus.in_branch_taken = 1'b0; bus.in_branch_addr = '0; bus.in_jump_addr = '0;
      bus.in_reg_write_enable = 1'b0; bus.in_wb_res_mux = 2'd0; bus.in_alu_res = '0;
      bus.in_mem_data = '0; bus.in_next_pc = '0; bus.in_imm = '0; bus.in_reg_dst = '0;
      bus.in_mem_size = 2'd0; bus.in_mem_signed = 1'b0; bus.in_mem_byte_off = 2'd0;

      s = blank(); s.rst = 1'b1;
      step(s); step(s);

      // ALU op
      s = blank(); s.valid = 1'b1; s.alu = 32'h1234; s.sel = 2'd0; s.dst = 5'd3; s.we = 1'b1;
      step(s);
      step(blank());

      // JAL with a 3-cycle stall, pulses counted over the window
      win_en = 1'b1;
      s = blank(); s.valid = 1'b1; s.sel = 2'd2; s.npc = 32'h41; s.jump = 1'b1;
      s.jaddr = 32'h80; s.we = 1'b1; s.dst = 5'd1;
      step(s);
      s.stall = 1'b1; s.valid = 1'b0; s.jump = 1'b0; s.npc = 32'h99;
      step(s); step(s); step(s);
      step(blank());
      @(posedge clk);
      #2;
      win_en = 1'b0;
      chk("jal_redirect_pulses", redir_seen, 32'd1);
      chk("jal_we_cycles", we_seen, 32'd4);

      // Branch and jump together
      s = blank(); s.valid = 1'b1; s.taken = 1'b1; s.jump = 1'b1;
      s.baddr = 32'h10; s.jaddr = 32'h20;
      step(s);

      // Flush with stall on a valid write, then a write to r0
      s = blank(); s.valid = 1'b1; s.we = 1'b1; s.dst = 5'd5; s.alu = 32'hABCD;
      s.stall = 1'b1; s.flush = 1'b1;
      step(s);
      s = blank(); s.valid = 1'b1; s.we = 1'b1; s.dst = 5'd0; s.alu = 32'h7;
      step(s);

      // Load shaping
      s = blank(); s.valid = 1'b1; s.we = 1'b1; s.dst = 5'd9; s.sel = 2'd1;
      s.mem = 32'h80FF_7F01; s.size = 2'b00; s.off = 2'd3; s.sgn = 1'b1;
      step(s);
      s.size = 2'b01; s.off = 2'd2; s.sgn = 1'b0;
      step(s);
      s.size = 2'b11; s.off = 2'd1; s.sgn = 1'b1;
      step(s);

      // Reset while stalled on a jump discards it
      s = blank(); s.valid = 1'b1; s.jump = 1'b1; s.jaddr = 32'h55; s.we = 1'b1; s.dst = 5'd7;
      step(s);
      s.stall = 1'b1; s.rst = 1'b1;
      step(s);
      s.rst = 1'b0;
      step(s); step(s);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         s.rst   = ($urandom_range(0, 49) == 0);
         s.stall = ($urandom_range(0, 3) == 0);
         s.flush = ($urandom_range(0, 9) == 0);
         s.valid = ($urandom_range(0, 4) != 0);
         s.jump  = ($urandom_range(0, 5) == 0);
         s.taken = ($urandom_range(0, 5) == 0);
         s.we    = $urandom_range(0, 1);
         s.sgn   = $urandom_range(0, 1);
         s.baddr = $urandom;
         s.jaddr = $urandom;
         s.alu   = $urandom;
         s.mem   = $urandom;
         s.npc   = $urandom;
         s.imm   = $urandom;
         s.sel   = $urandom_range(0, 3);
         s.size  = $urandom_range(0, 3);
         s.off   = $urandom_range(0, 3);
         s.dst   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
         step(s);
      end
      step(blank());

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      #2;
      chk("scoreboard_drained", exp_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
